// File: rtl/word_serializer_pkg.sv
// -----------------------------------------------------------------------------
// word_serializer_pkg
// Shared pipe constants for the 128-bit merge stage and the word serializer
// that follows it. The serializer takes its parameter defaults from here so
// both stages agree on beat and word geometry.
//   PIPE_DATA_WIDTH : beat width in bits
//   PIPE_WORD_WIDTH : serialized word width in bits
//   PIPE_WORDS      : words per beat
//   PIPE_IDX_WIDTH  : width of the word index counter
// -----------------------------------------------------------------------------
package word_serializer_pkg;

    localparam int PIPE_DATA_WIDTH = 128;
    localparam int PIPE_WORD_WIDTH = 32;
    localparam int PIPE_WORDS      = PIPE_DATA_WIDTH / PIPE_WORD_WIDTH;

    // A one-word beat still needs a 1-bit index so the vector is never empty.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    localparam int PIPE_IDX_WIDTH = idx_width(PIPE_WORDS);

endpackage

// File: rtl/word_serializer.sv
// -----------------------------------------------------------------------------
// word_serializer
// Splits each DATA_WIDTH beat into WORDS words of WORD_WIDTH bits, lowest word
// first. A beat is presented one cycle after it is accepted. A new beat may be
// accepted on the same edge that the final word of the current beat transfers,
// so back-to-back beats stream with no bubble.
//
// Ports
//   CLK           in   clock, all state on rising edge
//   nRST          in   asynchronous active-low reset
//   in_enq__ENA   in   upstream enqueue strobe
//   in_enq_v      in   upstream beat (DATA_WIDTH)
//   in_enq__RDY   out  beat can be accepted this cycle
//   out_enq__ENA  out  word transfer strobe (valid & downstream ready)
//   out_enq_v     out  current word (WORD_WIDTH), not gated by valid
//   out_enq_last  out  current word is the last word of its beat
//   out_enq__RDY  in   downstream can accept a word
// -----------------------------------------------------------------------------
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = PIPE_DATA_WIDTH,
    parameter int WORD_WIDTH = PIPE_WORD_WIDTH
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  in_enq__ENA,
    input  logic [DATA_WIDTH-1:0] in_enq_v,
    output logic                  in_enq__RDY,
    output logic                  out_enq__ENA,
    output logic [WORD_WIDTH-1:0] out_enq_v,
    output logic                  out_enq_last,
    input  logic                  out_enq__RDY
);

    localparam int               WORDS    = DATA_WIDTH / WORD_WIDTH;
    localparam int               IDX_W    = idx_width(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    logic [DATA_WIDTH-1:0] buffer_reg;
    logic                  valid_reg;
    logic [IDX_W-1:0]      idx_reg;

    logic                  at_last;
    logic                  xfer;
    logic                  accept;

    assign at_last = (idx_reg == LAST_IDX);
    assign xfer    = valid_reg & out_enq__RDY;

    // Ready only looks at state and downstream ready, never at the enqueue
    // strobe, so upstream can decide to enqueue without a combinational loop.
    assign in_enq__RDY = ~valid_reg | (at_last & out_enq__RDY);
    assign accept      = in_enq__ENA & in_enq__RDY;

    assign out_enq__ENA = xfer;
    assign out_enq_last = valid_reg & at_last;
    assign out_enq_v    = buffer_reg[int'(idx_reg) * WORD_WIDTH +: WORD_WIDTH];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            buffer_reg <= '0;
            valid_reg  <= 1'b0;
            idx_reg    <= '0;
        end else if (accept) begin
            // Also covers the last-word-plus-accept case: the new beat wins.
            buffer_reg <= in_enq_v;
            valid_reg  <= 1'b1;
            idx_reg    <= '0;
        end else if (xfer) begin
            if (at_last) begin
                valid_reg <= 1'b0;
                idx_reg   <= '0;
            end else begin
                idx_reg <= idx_reg + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// -----------------------------------------------------------------------------
// tb_word_serializer
// Directed bench for word_serializer with hand-computed expected words.
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns later,
// well away from the next edge.
// -----------------------------------------------------------------------------
module tb_word_serializer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_ena;
    logic [127:0] in_v;
    logic         in_rdy;
    logic         out_ena;
    logic [31:0]  out_v;
    logic         out_last;
    logic         out_rdy;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [127:0] BEAT_A = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    localparam logic [127:0] BEAT_B = 128'hAAAA_0003_AAAA_0002_AAAA_0001_AAAA_0000;
    localparam logic [127:0] BEAT_C = 128'hBBBB_0003_BBBB_0002_BBBB_0001_BBBB_0000;
    localparam logic [127:0] BEAT_D = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    localparam logic [127:0] BEAT_E = 128'hCCCC_0003_CCCC_0002_CCCC_0001_CCCC_0000;

    always #5 clk = ~clk;

    word_serializer dut (
        .CLK          (clk),
        .nRST         (rst_n),
        .in_enq__ENA  (in_ena),
        .in_enq_v     (in_v),
        .in_enq__RDY  (in_rdy),
        .out_enq__ENA (out_ena),
        .out_enq_v    (out_v),
        .out_enq_last (out_last),
        .out_enq__RDY (out_rdy)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [127:0] v, input logic r);
        in_ena  = e;
        in_v    = v;
        out_rdy = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic ena, input logic [31:0] w,
                              input logic last, input logic irdy);
        chk({tag, ".ena"},  {127'd0, out_ena},  {127'd0, ena});
        chk({tag, ".v"},    {96'd0, out_v},     {96'd0, w});
        chk({tag, ".last"}, {127'd0, out_last}, {127'd0, last});
        chk({tag, ".rdy"},  {127'd0, in_rdy},   {127'd0, irdy});
        $display("  %s: ena=%0b v=%08h last=%0b in_rdy=%0b", tag, out_ena, out_v, out_last, in_rdy);
    endtask

    function automatic logic [31:0] word_of(input logic [127:0] b, input int k);
        return b[k*32 +: 32];
    endfunction

    initial begin
        rst_n   = 1'b0;
        in_ena  = 1'b0;
        in_v    = '0;
        out_rdy = 1'b1;
        #1;
        expect_out("reset_async", 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        tick();
        expect_out("reset_held", 1'b0, 32'h0, 1'b0, 1'b1);
        rst_n = 1'b1;
        tick();
        expect_out("post_reset", 1'b0, 32'h0, 1'b0, 1'b1);

        // Single beat, downstream always ready.
        drive(1'b1, BEAT_A, 1'b1);
        expect_out("a.load", 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, 1'b1);
            expect_out($sformatf("a.w%0d", k), 1'b1, word_of(BEAT_A, k), k == 3, k == 3);
            tick();
        end
        drive(1'b0, '0, 1'b1);
        expect_out("a.idle", 1'b0, 32'h4444_4444 & 32'h0 | word_of(BEAT_A, 0), 1'b0, 1'b1);

        // Two beats back to back; second enqueue rides on the first beat's last word.
        drive(1'b1, BEAT_B, 1'b1);
        tick();
        for (int k = 0; k < 8; k++) begin
            if (k == 3) drive(1'b1, BEAT_C, 1'b1);
            else        drive(1'b0, '0, 1'b1);
            expect_out($sformatf("bb.w%0d", k), 1'b1,
                       (k < 4) ? word_of(BEAT_B, k) : word_of(BEAT_C, k - 4),
                       (k % 4) == 3, (k % 4) == 3);
            tick();
        end
        drive(1'b0, '0, 1'b1);
        expect_out("bb.idle", 1'b0, word_of(BEAT_C, 0), 1'b0, 1'b1);

        // Backpressure for 5 cycles after word 0: word 1 must hold.
        drive(1'b1, BEAT_A, 1'b1);
        tick();
        drive(1'b0, '0, 1'b1);
        expect_out("bp.w0", 1'b1, word_of(BEAT_A, 0), 1'b0, 1'b0);
        tick();
        for (int s = 0; s < 5; s++) begin
            drive(1'b0, '0, 1'b0);
            expect_out($sformatf("bp.stall%0d", s), 1'b0, 32'h2222_2222, 1'b0, 1'b0);
            tick();
        end
        for (int k = 1; k < 4; k++) begin
            drive(1'b0, '0, 1'b1);
            expect_out($sformatf("bp.w%0d", k), 1'b1, word_of(BEAT_A, k), k == 3, k == 3);
            tick();
        end

        // Enqueue while not ready (deliberate protocol violation): must be ignored.
        drive(1'b1, BEAT_B, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k == 1 || k == 2) drive(1'b1, BEAT_D, 1'b1);
            else                  drive(1'b0, '0, 1'b1);
            expect_out($sformatf("viol.w%0d", k), 1'b1, word_of(BEAT_B, k), k == 3, k == 3);
            tick();
        end
        drive(1'b0, '0, 1'b1);
        expect_out("viol.idle", 1'b0, word_of(BEAT_B, 0), 1'b0, 1'b1);

        // Asynchronous reset mid-beat, between clock edges.
        drive(1'b1, BEAT_C, 1'b1);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, '0, 1'b1);
            expect_out($sformatf("rst.w%0d", k), 1'b1, word_of(BEAT_C, k), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b1);
        expect_out("rst.w2", 1'b1, word_of(BEAT_C, 2), 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        expect_out("rst.pulse", 1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        rst_n = 1'b1;
        tick();
        expect_out("rst.after", 1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b1, BEAT_A, 1'b1);
        tick();
        drive(1'b0, '0, 1'b1);
        expect_out("rst.new_w0", 1'b1, word_of(BEAT_A, 0), 1'b0, 1'b0);
        tick();
        for (int k = 1; k < 4; k++) begin
            drive(1'b0, '0, 1'b1);
            tick();
        end

        // Stall on the last word with an enqueue pending; accept and last
        // transfer must happen on the same edge once downstream is ready.
        drive(1'b1, BEAT_B, 1'b1);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, 1'b1);
            tick();
        end
        for (int s = 0; s < 2; s++) begin
            drive(1'b1, BEAT_E, 1'b0);
            expect_out($sformatf("lst.stall%0d", s), 1'b0, word_of(BEAT_B, 3), 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, BEAT_E, 1'b1);
        expect_out("lst.release", 1'b1, word_of(BEAT_B, 3), 1'b1, 1'b1);
        tick();
        drive(1'b0, '0, 1'b1);
        expect_out("lst.new_w0", 1'b1, word_of(BEAT_E, 0), 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1);
        expect_out("lst.new_w1", 1'b1, word_of(BEAT_E, 1), 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety net so a broken design can never hang the run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
